data_evict_reader: RTL and testbench

Read-side companion to the cache data array's write path. On an eviction/writeback request it reads one victim cache line (512 bits) out of the data blockram as four 128-bit quarters, selects the victim way's slice, and streams the quarters to the memory-side writeback port under a valid/ready handshake. It sits between the cache controller (request side), the data array read port (`rd_addr`/`data_out`), and the memory write channel.

---
 rtl/cache_pkg.sv | 23 ++
 rtl/data_evict_reader.sv | 130 +++++++++++++
 tb/tb_data_evict_reader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache constants, typedefs and the eviction reader's state encoding.
package cache_pkg;

    localparam int unsigned SET_W      = 8;
    localparam int unsigned WAY_W      = 2;
    localparam int unsigned BEAT_W     = 2;
    localparam int unsigned LINE_OFF_W = 6;
    localparam int unsigned DATA_W     = 128;
    localparam int unsigned WAYS       = 4;
    localparam int unsigned LAST_BEAT  = 3;

    typedef logic [BEAT_W-1:0]      beat_t;
    typedef logic [WAY_W-1:0]       way_t;
    typedef logic [DATA_W-1:0]      beat_data_t;
    typedef logic [WAYS*DATA_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } evict_state_t;

endpackage

// File: rtl/data_evict_reader.sv
// Reads one victim line out of the data array as four quarters and streams them
// to the memory writeback port under a valid/ready handshake.
module data_evict_reader #(
    parameter int unsigned SET_W  = 8,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned WAYS   = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                   clk1,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [SET_W-1:0]       req_set,
    input  logic [1:0]             req_way,
    input  logic [ADDR_W-7:0]      req_line_addr,
    output logic [SET_W+1:0]       rd_addr,
    input  logic [WAYS*DATA_W-1:0] rd_data,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_data,
    output logic                   mem_last,
    output logic                   done,
    output logic                   busy
);
    import cache_pkg::*;

    evict_state_t            r_state;
    evict_state_t            w_state_d;
    logic [SET_W-1:0]        r_set;
    logic [1:0]              r_way;
    logic [ADDR_W-7:0]       r_line;
    beat_t                   r_beat;
    logic                    r_mem_valid;
    logic [DATA_W-1:0]       r_mem_data;
    logic                    r_done;

    logic [DATA_W-1:0]       w_slice;
    beat_t                   w_beat_inc;
    logic                    w_is_last;
    logic                    w_fire;
    logic [SET_W+1:0]        w_rd_addr;

    assign w_slice    = rd_data[DATA_W*r_way +: DATA_W];
    assign w_beat_inc = r_beat + beat_t'(1);
    assign w_is_last  = (r_beat == beat_t'(LAST_BEAT));
    assign w_fire     = r_mem_valid & mem_ready;

    always_comb begin
        w_state_d = r_state;
        w_rd_addr = '0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_d = LOAD;
                end
            end
            LOAD: begin
                w_rd_addr = {r_set, r_beat};
                w_state_d = SEND;
            end
            SEND: begin
                // Prefetch the next quarter so a handshake can reload with no bubble.
                w_rd_addr = {r_set, w_beat_inc};
                if (w_fire && w_is_last) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            r_set       <= '0;
            r_way       <= '0;
            r_line      <= '0;
            r_beat      <= '0;
            r_mem_valid <= 1'b0;
            r_mem_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_set  <= req_set;
                        r_way  <= req_way;
                        r_line <= req_line_addr;
                        r_beat <= '0;
                    end
                end
                LOAD: begin
                    r_mem_data  <= w_slice;
                    r_mem_valid <= 1'b1;
                end
                SEND: begin
                    if (w_fire) begin
                        if (w_is_last) begin
                            r_mem_valid <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_mem_data <= w_slice;
                            r_beat     <= w_beat_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign rd_addr   = w_rd_addr;
    assign mem_valid = r_mem_valid;
    assign mem_data  = r_mem_data;
    assign mem_addr  = {r_line, r_beat, {(LINE_OFF_W-BEAT_W){1'b0}}};
    assign mem_last  = r_mem_valid & w_is_last;
    assign done      = r_done;

endmodule

// File: tb/tb_data_evict_reader.sv
// Scoreboard bench for data_evict_reader: random and directed evictions against a
// line-level model of the data array and the expected writeback beat stream.
module tb_data_evict_reader;

    logic           clk1;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [7:0]     req_set;
    logic [1:0]     req_way;
    logic [25:0]    req_line_addr;
    logic [9:0]     rd_addr;
    logic [511:0]   rd_data;
    logic           mem_valid;
    logic           mem_ready;
    logic [31:0]    mem_addr;
    logic [127:0]   mem_data;
    logic           mem_last;
    logic           done;
    logic           busy;

    data_evict_reader #(
        .SET_W (8),
        .DATA_W(128),
        .WAYS  (4),
        .ADDR_W(32)
    ) dut (
        .clk1         (clk1),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_set      (req_set),
        .req_way      (req_way),
        .req_line_addr(req_line_addr),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_last     (mem_last),
        .done         (done),
        .busy         (busy)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Data array model: arr[{set, quarter}][way]
    logic [127:0] arr [1024][4];
    for (genvar w = 0; w < 4; w++) begin : g_rd
        assign rd_data[w*128 +: 128] = arr[rd_addr][w];
    end

    typedef struct {
        logic [7:0]   set;
        logic [1:0]   beat;
        logic [31:0]  addr;
        logic [127:0] data;
        logic         last;
        int           req_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   beats_acc = 0;
    logic exp_done = 1'b0;
    bit   head_chk = 1'b0;

    int         rmode = 0;
    int         pidx  = 0;
    logic [6:0] pat   = 7'b1101001;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    always @(posedge clk1) cyc++;

    always @(posedge clk1) begin
        #1;
        case (rmode)
            0: mem_ready = 1'b1;
            1: begin
                mem_ready = pat[pidx];
                pidx = (pidx == 6) ? 0 : pidx + 1;
            end
            default: mem_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compares every presented beat against the scoreboard head.
    always @(negedge clk1) begin
        exp_t h;
        logic nxt;
        if (!rst) begin
            sb.delete();
            exp_done = 1'b0;
            head_chk = 1'b0;
        end else begin
            chk("done", 128'(done), 128'(exp_done));
            nxt = 1'b0;
            if (mem_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 128'(1), 128'(0));
                end else begin
                    h = sb[0];
                    chk("mem_addr", 128'(mem_addr), 128'(h.addr));
                    chk("mem_data", mem_data, h.data);
                    chk("mem_last", 128'(mem_last), 128'(h.last));
                    chk("rd_addr_send", 128'(rd_addr), 128'({h.set, 2'(h.beat + 2'd1)}));
                    if (h.beat == 2'd0 && !head_chk) begin
                        chk("first_beat_latency", 128'(cyc), 128'(h.req_cyc + 2));
                        head_chk = 1'b1;
                    end
                    if (mem_ready) begin
                        void'(sb.pop_front());
                        head_chk = 1'b0;
                        beats_acc++;
                        if (h.last) nxt = 1'b1;
                    end
                end
            end else if (busy && sb.size() != 0) begin
                h = sb[0];
                chk("rd_addr_load", 128'(rd_addr), 128'({h.set, 2'b00}));
            end
            if (req_valid && req_ready) begin
                for (int b = 0; b < 4; b++) begin
                    h.set     = req_set;
                    h.beat    = 2'(b);
                    h.addr    = {req_line_addr, 2'(b), 4'b0000};
                    h.data    = arr[{req_set, 2'(b)}][req_way];
                    h.last    = (b == 3);
                    h.req_cyc = cyc;
                    sb.push_back(h);
                end
            end
            exp_done = nxt;
        end
    end

    task automatic do_req(input logic [7:0] s, input logic [1:0] w, input logic [25:0] l,
                          input bit drop, output int acc);
        req_set       = s;
        req_way       = w;
        req_line_addr = l;
        req_valid     = 1'b1;
        acc           = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk1);
            if (req_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("req_accept_timeout", 128'(0), 128'(1));
        @(posedge clk1);
        #1;
        if (drop || acc < 0) req_valid = 1'b0;
    endtask

    task automatic wait_done(output int d);
        d = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk1);
            if (done) begin
                d = cyc;
                break;
            end
        end
        if (d < 0) chk("done_timeout", 128'(0), 128'(1));
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk1);
            #1;
            if (sb.size() == 0 && !busy && !done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 128'(0), 128'(1));
        @(posedge clk1);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_valid"}, 128'(mem_valid), 128'(0));
        chk({tag, "_done"},      128'(done),      128'(0));
        chk({tag, "_rd_addr"},   128'(rd_addr),   128'(0));
        chk({tag, "_req_ready"}, 128'(req_ready), 128'(1));
        chk({tag, "_busy"},      128'(busy),      128'(0));
        chk({tag, "_mem_addr"},  128'(mem_addr),  128'(0));
        chk({tag, "_mem_last"},  128'(mem_last),  128'(0));
    endtask

    initial begin
        int c1, c2, d, base;
        logic [7:0] s;
        bit drop;

        rst = 1'b0;
        req_valid = 1'b0;
        req_set = '0;
        req_way = '0;
        req_line_addr = '0;
        mem_ready = 1'b0;
        for (int a = 0; a < 1024; a++)
            for (int w = 0; w < 4; w++)
                arr[a][w] = {$urandom, $urandom, $urandom, $urandom};
        for (int q = 0; q < 4; q++)
            arr[{8'h5A, 2'(q)}][2] = {16{8'(8'hA0 + q)}};

        #3;
        chk_reset_outputs("por");
        repeat (2) @(posedge clk1);
        #1;
        rst = 1'b1;
        repeat (4) @(posedge clk1);
        #1;
        chk("idle_quiet_valid", 128'(mem_valid), 128'(0));

        // Basic eviction with memory always ready
        rmode = 0;
        do_req(8'h5A, 2'd2, 26'h123456, 1'b1, c1);
        wait_done(d);
        chk("req_to_done_cycles", 128'(d - c1), 128'(6));
        wait_drain();

        // Backpressure pattern 1,0,0,1,0,1,1
        pidx = 0;
        rmode = 1;
        base = beats_acc;
        do_req(8'h5A, 2'd2, 26'h0ABCDE, 1'b1, c1);
        wait_drain();
        chk("bp_beat_count", 128'(beats_acc - base), 128'(4));
        rmode = 0;

        // Way select at both ends of rd_data
        do_req(8'h5A, 2'd0, 26'h000111, 1'b1, c1);
        wait_drain();
        do_req(8'h5A, 2'd3, 26'h000222, 1'b1, c1);
        wait_drain();

        // Back-to-back: second request accepted in the done cycle of the first
        do_req(8'h10, 2'd1, 26'h3000001, 1'b0, c1);
        do_req(8'h20, 2'd3, 26'h2000002, 1'b1, c2);
        chk("b2b_accept_cycle", 128'(c2 - c1), 128'(6));
        wait_drain();

        // Reset after beat 1 is accepted
        base = beats_acc;
        do_req(8'h33, 2'd1, 26'h1555555, 1'b1, c1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk1);
            #1;
            if (beats_acc >= base + 2) break;
        end
        chk("mid_reset_beats_before", 128'(beats_acc - base), 128'(2));
        @(posedge clk1);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("mid");
        repeat (2) @(posedge clk1);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk1);
            chk("no_done_after_reset", 128'(done), 128'(0));
        end
        @(posedge clk1);
        #1;
        do_req(8'h33, 2'd1, 26'h0000ABC, 1'b1, c1);
        wait_drain();

        // Randomized requests with random memory backpressure
        rmode = 2;
        for (int i = 0; i < 24; i++) begin
            s = 8'($urandom);
            drop = ($urandom_range(0, 3) != 0) || (i == 23);
            do_req(s, 2'($urandom), 26'($urandom), drop, c1);
            if (drop) repeat ($urandom_range(0, 3)) @(posedge clk1);
        end
        wait_drain();
        rmode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
